// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset core
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [31:0]          Inst_i,
    input  logic                 Zero_i,
    input  logic                 Mem_ack_i,
    output logic                 Mem_req_o,
    output logic                 Mem_we_o,
    output logic                 Mem_addr_sel_o,
    output logic                 IR_we_o,
    output logic                 PC_we_o,
    output logic                 PC_sel_o,
    output logic                 ALUSrc_o,
    output logic [1:0]           ALUOp_o,
    output logic                 RegWrite_o,
    output logic                 WB_sel_o,
    output logic                 Halt_o,
    output logic [1:0]           Err_code_o,
    output logic                 Retire_o,
    output logic [CNT_WIDTH-1:0] Retired_cnt_o
);
    localparam int            TW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t         state, state_next;
    logic [TW-1:0]  tmo_cnt;
    logic [1:0]     err_q, err_next;
    logic [CNT_WIDTH-1:0] retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_op_imm, is_op, is_load, is_store, is_branch, is_legal;
    logic       taken, tmo_hit;
    state_t     retire_next;
    logic       unused_inst;

    assign opcode      = Inst_i[6:0];
    assign funct3      = Inst_i[14:12];
    assign unused_inst = ^{Inst_i[31:15], Inst_i[11:7]};
    assign is_op_imm   = (opcode == OPC_OP_IMM);
    assign is_op       = (opcode == OPC_OP);
    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign is_branch   = (opcode == OPC_BRANCH) && (funct3 == 3'b000 || funct3 == 3'b001);
    assign is_legal    = is_op_imm | is_op | is_load | is_store | is_branch;
    // funct3[0] distinguishes BNE from BEQ
    assign taken       = funct3[0] ? !Zero_i : Zero_i;
    // an ack in the last allowed waiting cycle still wins over the timeout
    assign tmo_hit     = (tmo_cnt == TMO_LAST) && !Mem_ack_i;
    assign retire_next = stop_i ? S_IDLE : S_FETCH;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            err_q     <= 2'b00;
            retired_q <= '0;
        end else begin
            state <= state_next;
            err_q <= err_next;
            if ((state == S_FETCH || state == S_MEM) && !Mem_ack_i)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
            if (Retire_o)
                retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next     = state;
        err_next       = err_q;
        Mem_req_o      = 1'b0;
        Mem_we_o       = 1'b0;
        Mem_addr_sel_o = 1'b0;
        IR_we_o        = 1'b0;
        PC_we_o        = 1'b0;
        PC_sel_o       = 1'b0;
        ALUSrc_o       = 1'b0;
        ALUOp_o        = 2'b00;
        RegWrite_o     = 1'b0;
        WB_sel_o       = 1'b0;
        Halt_o         = 1'b0;
        Retire_o       = 1'b0;

        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            ALUSrc_o = is_op_imm | is_load | is_store;
            if (is_load || is_store)
                ALUOp_o = 2'b00;
            else if (is_branch)
                ALUOp_o = 2'b01;
            else
                ALUOp_o = 2'b10;
        end

        case (state)
            S_IDLE: begin
                if (start_i)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                Mem_req_o = 1'b1;
                if (Mem_ack_i) begin
                    IR_we_o    = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_HALT;
                    err_next   = 2'b10;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_HALT;
                    err_next   = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    PC_we_o    = 1'b1;
                    PC_sel_o   = taken;
                    Retire_o   = 1'b1;
                    state_next = retire_next;
                end else if (is_op || is_op_imm) begin
                    state_next = S_WB;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_HALT;
                    err_next   = 2'b01;
                end
            end
            S_MEM: begin
                Mem_req_o      = 1'b1;
                Mem_addr_sel_o = 1'b1;
                Mem_we_o       = is_store;
                if (Mem_ack_i) begin
                    if (is_store) begin
                        PC_we_o    = 1'b1;
                        Retire_o   = 1'b1;
                        state_next = retire_next;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_next = S_HALT;
                    err_next   = 2'b10;
                end
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                WB_sel_o   = is_load;
                PC_we_o    = 1'b1;
                Retire_o   = 1'b1;
                state_next = retire_next;
            end
            S_HALT: begin
                Halt_o = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign Err_code_o    = err_q;
    assign Retired_cnt_o = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [31:0] Inst_i = 32'h0;
    logic        Zero_i = 1'b0;
    logic        Mem_ack_i = 1'b0;
    logic        Mem_req_o, Mem_we_o, Mem_addr_sel_o, IR_we_o, PC_we_o, PC_sel_o;
    logic        ALUSrc_o, RegWrite_o, WB_sel_o, Halt_o, Retire_o;
    logic [1:0]  ALUOp_o, Err_code_o;
    logic [31:0] Retired_cnt_o;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .Inst_i(Inst_i), .Zero_i(Zero_i), .Mem_ack_i(Mem_ack_i),
        .Mem_req_o(Mem_req_o), .Mem_we_o(Mem_we_o), .Mem_addr_sel_o(Mem_addr_sel_o),
        .IR_we_o(IR_we_o), .PC_we_o(PC_we_o), .PC_sel_o(PC_sel_o),
        .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o), .RegWrite_o(RegWrite_o),
        .WB_sel_o(WB_sel_o), .Halt_o(Halt_o), .Err_code_o(Err_code_o),
        .Retire_o(Retire_o), .Retired_cnt_o(Retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic        zero;
        int          fw;
        int          mw;
        int          cyc;
        logic        halt;
        logic [1:0]  err;
        logic        rw;
        logic        we;
        int          memreq;
        logic        pcsel;
        logic        wbsel;
        logic        alusrc;
        logic [1:0]  aluop;
    } vec_t;

    vec_t vecs[14];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_cnt = 0;

    int          r_cyc, r_memreq;
    logic        r_halt, r_rw, r_we, r_pcwe, r_pcsel, r_wbsel, r_alusrc;
    logic [1:0]  r_aluop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reset_start();
        @(negedge clk_i);
        rst_i = 1'b1; Mem_ack_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // memory model: acks after fw (fetch) or mw (data) unacked request cycles
    task automatic run_instr(input logic [31:0] inst, input logic zero, input int fw, input int mw,
                             input logic stop);
        int waits;
        waits = 0;
        r_cyc = 0; r_memreq = 0; r_halt = 0; r_rw = 0; r_we = 0; r_pcwe = 0;
        r_pcsel = 0; r_wbsel = 0; r_alusrc = 0; r_aluop = 2'b00;
        Inst_i = inst; Zero_i = zero; stop_i = stop;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            Mem_ack_i = 1'b0;
            #1;
            if (Mem_req_o) begin
                if (waits == (Mem_addr_sel_o ? mw : fw)) begin
                    Mem_ack_i = 1'b1;
                    waits = 0;
                end else begin
                    waits++;
                end
            end
            #1;
            r_cyc++;
            if (RegWrite_o) r_rw = 1'b1;
            if (Mem_we_o) r_we = 1'b1;
            if (PC_we_o) r_pcwe = 1'b1;
            if (Mem_req_o && Mem_addr_sel_o) r_memreq++;
            if (Halt_o) begin
                r_halt = 1'b1;
                break;
            end
            if (Retire_o) begin
                r_pcsel = PC_sel_o; r_wbsel = WB_sel_o;
                r_alusrc = ALUSrc_o; r_aluop = ALUOp_o;
                break;
            end
        end
        @(posedge clk_i);
        #1 Mem_ack_i = 1'b0; stop_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             inst          z  fw  mw  cyc halt err   rw we mreq pcs wbs src op
        vecs[0]  = '{32'h00500093, 0,  0,  0,  4, 0, 2'd0, 1, 0, 0, 0, 0, 1, 2'd2};
        vecs[1]  = '{32'h0000A103, 0,  0,  3,  8, 0, 2'd0, 1, 0, 4, 0, 1, 1, 2'd0};
        vecs[2]  = '{32'h00000463, 1,  0,  0,  3, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd1};
        vecs[3]  = '{32'h00000463, 0,  0,  0,  3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1};
        vecs[4]  = '{32'h00001463, 1,  0,  0,  3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1};
        vecs[5]  = '{32'h00001463, 0,  0,  0,  3, 0, 2'd0, 0, 0, 0, 1, 0, 0, 2'd1};
        vecs[6]  = '{32'h0020A023, 0,  0,  0,  4, 0, 2'd0, 0, 1, 1, 0, 0, 1, 2'd0};
        vecs[7]  = '{32'h002081B3, 0,  0,  0,  4, 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd2};
        vecs[8]  = '{32'h00500093, 0,  3,  0,  7, 0, 2'd0, 1, 0, 0, 0, 0, 1, 2'd2};
        vecs[9]  = '{32'h0020A023, 0,  0,  2,  6, 0, 2'd0, 0, 1, 3, 0, 0, 1, 2'd0};
        vecs[10] = '{32'h0000007F, 0,  0,  0,  3, 1, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0};
        vecs[11] = '{32'h00002463, 0,  0,  0,  3, 1, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0};
        vecs[12] = '{32'h00500093, 0, 99,  0,  5, 1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0};
        vecs[13] = '{32'h0000A103, 0,  0, 99,  8, 1, 2'd2, 0, 0, 4, 0, 0, 0, 2'd0};

        // reset state
        #12;
        check("reset Mem_req_o", 32'(Mem_req_o), 32'd0);
        check("reset Halt_o", 32'(Halt_o), 32'd0);
        check("reset Err_code_o", 32'(Err_code_o), 32'd0);
        check("reset Retired_cnt_o", Retired_cnt_o, 32'd0);
        check("reset controls", 32'({Mem_we_o, Mem_addr_sel_o, IR_we_o, PC_we_o, PC_sel_o, ALUSrc_o,
                                     ALUOp_o, RegWrite_o, WB_sel_o, Retire_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1 check("idle without start", 32'(Mem_req_o), 32'd0);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_instr(vecs[i].inst, vecs[i].zero, vecs[i].fw, vecs[i].mw, 1'b0);
            if (!vecs[i].halt) exp_cnt++;
            check($sformatf("v%0d cycles", i), 32'(r_cyc), 32'(vecs[i].cyc));
            check($sformatf("v%0d halted", i), 32'(r_halt), 32'(vecs[i].halt));
            check($sformatf("v%0d err_code", i), 32'(Err_code_o), 32'(vecs[i].err));
            check($sformatf("v%0d regwrite", i), 32'(r_rw), 32'(vecs[i].rw));
            check($sformatf("v%0d mem_we", i), 32'(r_we), 32'(vecs[i].we));
            check($sformatf("v%0d pc_we", i), 32'(r_pcwe), 32'(!vecs[i].halt));
            check($sformatf("v%0d mem_req cycles", i), 32'(r_memreq), 32'(vecs[i].memreq));
            check($sformatf("v%0d retired_cnt", i), Retired_cnt_o, 32'(exp_cnt));
            if (!vecs[i].halt) begin
                check($sformatf("v%0d pc_sel", i), 32'(r_pcsel), 32'(vecs[i].pcsel));
                check($sformatf("v%0d wb_sel", i), 32'(r_wbsel), 32'(vecs[i].wbsel));
                check($sformatf("v%0d alu_src", i), 32'(r_alusrc), 32'(vecs[i].alusrc));
                check($sformatf("v%0d alu_op", i), 32'(r_aluop), 32'(vecs[i].aluop));
            end else begin
                reset_start();
                exp_cnt = 0;
            end
        end

        // HALT ignores start_i and holds the error code
        run_instr(32'h00500093, 1'b0, 0, 0, 1'b0);
        run_instr(32'h0000007F, 1'b0, 0, 0, 1'b0);
        start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("halt start ignored", 32'(Halt_o), 32'd1);
        check("halt no mem_req", 32'(Mem_req_o), 32'd0);
        check("halt err held", 32'(Err_code_o), 32'd1);
        check("halt cnt unchanged", Retired_cnt_o, 32'd1);
        start_i = 1'b0;
        reset_start();

        // stop_i during retire returns to IDLE, start_i restarts
        run_instr(32'h00500093, 1'b0, 0, 0, 1'b1);
        check("stop cycles", 32'(r_cyc), 32'd4);
        repeat (2) @(negedge clk_i);
        #1 check("stop idle req", 32'(Mem_req_o), 32'd0);
        check("stop idle halt", 32'(Halt_o), 32'd0);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        run_instr(32'h00500093, 1'b0, 0, 0, 1'b0);
        check("restart cycles", 32'(r_cyc), 32'd4);
        check("restart cnt", Retired_cnt_o, 32'd2);

        // asynchronous reset in the middle of a data access
        Inst_i = 32'h0000A103;
        @(negedge clk_i);
        Mem_ack_i = 1'b1;
        @(negedge clk_i);
        Mem_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("mid-mem req", 32'(Mem_req_o), 32'd1);
        check("mid-mem addr_sel", 32'(Mem_addr_sel_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async rst req drop", 32'(Mem_req_o), 32'd0);
        check("async rst cnt", Retired_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1 check("after rst idle", 32'(Mem_req_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
